// File: rtl/ex_arith_unit.sv
// ex_arith_unit: execute-stage ALU, branch-target and pc+4 adders, and free-running cycle counter.
// Every output is registered, so results arrive in EX/MEM one cycle after the operands.
module ex_arith_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  pc,
    input  logic             alu_src,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             branch,
    output logic             out_valid,
    output logic [XLEN-1:0]  alu_result,
    output logic             zero,
    output logic             take_branch,
    output logic [XLEN-1:0]  branch_target,
    output logic [XLEN-1:0]  pc_plus4,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int SH_W = $clog2(XLEN);

    logic [XLEN-1:0] b, res;
    logic [SH_W-1:0] sh;

    always_comb begin
        b   = alu_src ? imm : rs2_data;
        sh  = b[SH_W-1:0];
        res = '0;
        if (alu_op == 2'b00)
            res = rs1_data + b;
        else if (alu_op == 2'b01)
            res = rs1_data - b;
        else
            case (funct3)
                3'b000: res = (alu_op == 2'b10 && funct7_5) ? rs1_data - b : rs1_data + b;
                3'b001: res = rs1_data << sh;
                3'b010: res = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(b)};
                3'b011: res = {{(XLEN-1){1'b0}}, rs1_data < b};
                3'b100: res = rs1_data ^ b;
                3'b101: res = funct7_5 ? $unsigned($signed(rs1_data) >>> sh) : rs1_data >> sh;
                3'b110: res = rs1_data | b;
                default: res = rs1_data & b;
            endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            alu_result    <= '0;
            zero          <= 1'b0;
            take_branch   <= 1'b0;
            branch_target <= '0;
            pc_plus4      <= '0;
            cycle_count   <= '0;
        end else begin
            out_valid     <= in_valid;
            alu_result    <= res;
            zero          <= res == '0;
            take_branch   <= branch && res == '0;
            branch_target <= pc + (imm << 1);
            pc_plus4      <= pc + XLEN'(4);
            cycle_count   <= cycle_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_ex_arith_unit.sv
// tb_ex_arith_unit: directed scoreboard bench for ex_arith_unit.
module tb_ex_arith_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] rs1_data = '0, rs2_data = '0, imm = '0, pc = '0;
    logic        alu_src = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7_5 = 1'b0, branch = 1'b0;
    logic        out_valid, zero, take_branch;
    logic [63:0] alu_result, branch_target, pc_plus4, cycle_count;
    logic        s_valid, s_zero, s_take;
    logic [63:0] s_res, s_bt, s_p4;
    logic [3:0]  s_cnt;

    typedef struct packed {
        logic        v;
        logic [63:0] r;
        logic        z;
        logic        t;
        logic [63:0] bt;
        logic [63:0] p4;
    } exp_t;

    exp_t  q[$];
    string tags[$];
    int    tests = 0;
    int    fails = 0;

    ex_arith_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .pc(pc), .alu_src(alu_src), .alu_op(alu_op), .funct3(funct3),
        .funct7_5(funct7_5), .branch(branch), .out_valid(out_valid), .alu_result(alu_result),
        .zero(zero), .take_branch(take_branch), .branch_target(branch_target),
        .pc_plus4(pc_plus4), .cycle_count(cycle_count)
    );

    ex_arith_unit #(.XLEN(64), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .pc(pc), .alu_src(alu_src), .alu_op(alu_op), .funct3(funct3),
        .funct7_5(funct7_5), .branch(branch), .out_valid(s_valid), .alu_result(s_res),
        .zero(s_zero), .take_branch(s_take), .branch_target(s_bt),
        .pc_plus4(s_p4), .cycle_count(s_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [63:0] a, input logic [63:0] b2,
                        input logic [63:0] im, input logic [63:0] p, input logic src,
                        input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic br, input logic [63:0] er);
        exp_t  e;
        string t;
        @(negedge clk);
        in_valid = v; rs1_data = a; rs2_data = b2; imm = im; pc = p;
        alu_src = src; alu_op = op; funct3 = f3; funct7_5 = f7; branch = br;
        q.push_back('{v: v, r: er, z: er == 0, t: br && er == 0, bt: p + (im << 1), p4: p + 64'd4});
        tags.push_back(tag);
        @(posedge clk);
        #1;
        e = q.pop_front();
        t = tags.pop_front();
        chk({t, ".valid"}, {63'b0, out_valid}, {63'b0, e.v});
        chk({t, ".result"}, alu_result, e.r);
        chk({t, ".zero"}, {63'b0, zero}, {63'b0, e.z});
        chk({t, ".take"}, {63'b0, take_branch}, {63'b0, e.t});
        chk({t, ".target"}, branch_target, e.bt);
        chk({t, ".pc4"}, pc_plus4, e.p4);
    endtask

    initial begin
        logic [63:0] prev;
        int n;
        in_valid = 1'b1; rs1_data = 64'h55; rs2_data = 64'h33; pc = 64'h40; imm = 64'h2;
        repeat (2) @(negedge clk);
        chk("reset_hold.result", alu_result, 64'h0);
        chk("reset_hold.count", cycle_count, 64'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("release.count", cycle_count, 64'd1);

        step("add",      1, 64'd5, 64'd7, 64'd99, 64'h200, 0, 2'b00, 3'b111, 1, 0, 64'd12);
        step("sub_zero", 1, 64'h1234, 64'h1234, 64'd0, 64'h204, 0, 2'b01, 3'b000, 0, 0, 64'd0);
        step("sub_wrap", 1, 64'd0, 64'd1, 64'd0, 64'h208, 0, 2'b01, 3'b000, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        step("sra",      1, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'h20c, 0, 2'b10, 3'b101, 1, 0, 64'hF800_0000_0000_0000);
        step("srl",      1, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'h210, 0, 2'b10, 3'b101, 0, 0, 64'h0800_0000_0000_0000);
        step("slt",      1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'h214, 0, 2'b10, 3'b010, 0, 0, 64'd1);
        step("sltu",     1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'h218, 0, 2'b10, 3'b011, 0, 0, 64'd0);
        step("sll",      1, 64'd1, 64'h44, 64'd0, 64'h21c, 0, 2'b10, 3'b001, 0, 0, 64'd16);
        step("xor",      1, 64'hF0F0, 64'h0FF0, 64'd0, 64'h220, 0, 2'b10, 3'b100, 0, 0, 64'hFF00);
        step("or",       1, 64'hF0F0, 64'h0FF0, 64'd0, 64'h224, 0, 2'b10, 3'b110, 0, 0, 64'hFFF0);
        step("and",      1, 64'hF0F0, 64'h0FF0, 64'd0, 64'h228, 0, 2'b10, 3'b111, 0, 0, 64'h00F0);
        step("rsub",     1, 64'd10, 64'd3, 64'd0, 64'h22c, 0, 2'b10, 3'b000, 1, 0, 64'd7);
        step("addi",     1, 64'd10, 64'd999, 64'hFFFF_FFFF_FFFF_FFFD, 64'h230, 1, 2'b11, 3'b000, 1, 0, 64'd7);
        step("beq_take", 1, 64'd9, 64'd9, 64'd8, 64'h100, 0, 2'b01, 3'b000, 0, 1, 64'd0);
        chk("beq_take.target_const", branch_target, 64'h110);
        chk("beq_take.pc4_const", pc_plus4, 64'h104);
        step("beq_not",  1, 64'd9, 64'd8, 64'd8, 64'h100, 0, 2'b01, 3'b000, 0, 1, 64'd1);
        step("pc_wrap",  1, 64'd1, 64'd1, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFC, 0, 2'b00, 3'b000, 0, 0, 64'd2);
        chk("pc_wrap.pc4_const", pc_plus4, 64'd0);
        step("vpulse_lo", 0, 64'd1, 64'd2, 64'd0, 64'h300, 0, 2'b00, 3'b000, 0, 0, 64'd3);
        step("vpulse_hi", 1, 64'd1, 64'd2, 64'd0, 64'h304, 0, 2'b00, 3'b000, 0, 0, 64'd3);
        step("vpulse_after", 0, 64'd4, 64'd2, 64'd0, 64'h308, 0, 2'b00, 3'b000, 0, 0, 64'd6);

        step("pre_reset", 1, 64'd20, 64'd22, 64'd5, 64'h400, 0, 2'b00, 3'b000, 0, 0, 64'd42);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst.valid", {63'b0, out_valid}, 64'd0);
        chk("async_rst.result", alu_result, 64'd0);
        chk("async_rst.target", branch_target, 64'd0);
        chk("async_rst.pc4", pc_plus4, 64'd0);
        chk("async_rst.count", cycle_count, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rerelease.count", cycle_count, 64'd1);
        chk("rerelease.count_small", {60'b0, s_cnt}, 64'd1);

        n = 0;
        while (s_cnt !== 4'hF && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("cnt_small_allones", {60'b0, s_cnt}, 64'hF);
        prev = cycle_count;
        @(posedge clk);
        #1;
        chk("cnt_small_wrap", {60'b0, s_cnt}, 64'd0);
        chk("cnt_big_inc", cycle_count, prev + 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
